// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: edge feeder for the systolic MAC array.
// Each accepted vector beat is injected into every lane's delay line. Lane i
// is an (i+1)-stage register chain, so element k of all rows arrives at the
// left-column PEs as a diagonal wavefront. The chains shift every cycle, and
// zero bubbles fill any cycle without an accepted beat.
// Optional build macro FEEDER_PERF_CNT_EN adds the bubble_cnt_o counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start with a nonzero tile length
// ST_FEED  | in_ready high; accepting beats until K have been taken
// ST_DRAIN | LANES cycles flushing the diagonal; done pulses on the last one

module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [LEN_WIDTH-1:0]        tile_len_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0] in_data_i,
  output logic [LANES*DATA_WIDTH-1:0] out_data_o,
  output logic [LANES-1:0]            out_valid_o,
  output logic                        busy_o,
  output logic                        done_o
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]                 bubble_cnt_o
`endif
);

  localparam int DCW = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                      state_q;
  logic [LEN_WIDTH-1:0]        beats_left_q;
  logic [DCW-1:0]              drain_cnt_q;
  logic                        done_q;

  logic                        start_acc;
  logic                        beat_acc;
  logic [LANES*DATA_WIDTH-1:0] inj_data;

  assign start_acc  = (state_q == ST_IDLE) && start_i && (tile_len_i != '0);
  assign beat_acc   = (state_q == ST_FEED) && in_valid_i;
  // A bubble carries zero data as well as valid=0, so the PEs see clean zeros.
  assign inj_data   = beat_acc ? in_data_i : '0;

  assign in_ready_o = (state_q == ST_FEED);
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;

  // Tile sequencer: beats-remaining and drain timers are down-counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      drain_cnt_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            state_q      <= ST_FEED;
            beats_left_q <= tile_len_i;
          end
        end
        ST_FEED: begin
          if (beat_acc) begin
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == LEN_WIDTH'(1)) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= DCW'(LANES - 1);
            end
          end
        end
        ST_DRAIN: begin
          // done is registered, so it is armed one cycle before the last
          // lane shows the final beat.
          if (drain_cnt_q == DCW'(1)) begin
            done_q <= 1'b1;
          end
          if (drain_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [0:i];
    logic [i:0]            vld_q;

    // Lane i delay line: i+1 stages, the last one is the output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j <= i; j++) begin
          dat_q[j] <= '0;
        end
        vld_q <= '0;
      end else begin
        dat_q[0] <= inj_data[i*DATA_WIDTH +: DATA_WIDTH];
        vld_q[0] <= beat_acc;
        for (int j = 1; j <= i; j++) begin
          dat_q[j] <= dat_q[j-1];
          vld_q[j] <= vld_q[j-1];
        end
      end
    end

    assign out_data_o[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
    assign out_valid_o[i]                         = vld_q[i];
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] bubble_cnt_q;
  logic [15:0] bubble_cnt_d;

  // Count FEED cycles without an accepted beat; saturate, clear on new tile.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (start_acc) begin
      bubble_cnt_d = '0;
    end else if ((state_q == ST_FEED) && !beat_acc && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (LANES=4, DATA_WIDTH=32).
// Accepted beats push per-lane expectations (due cycle, lane, data) into a
// scoreboard; each cycle the due entries are popped and compared.
module tb_systolic_skew_feeder;
  localparam int DW = 32;
  localparam int L  = 4;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [LW-1:0]   tile_len;
  logic            in_valid;
  logic            in_ready;
  logic [L*DW-1:0] in_data;
  logic [L*DW-1:0] out_data;
  logic [L-1:0]    out_valid;
  logic            busy;
  logic            done;
`ifdef FEEDER_PERF_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(L), .LEN_WIDTH(LW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .tile_len_i  (tile_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .busy_o      (busy),
    .done_o      (done)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .bubble_cnt_o(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    int            lane;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   cur = 0;
  int   npass = 0;
  int   ntot = 0;
  int   nfail = 0;
  int   busy_from = 0;
  int   busy_until = -1;
  int   done_cyc = -1;
  int   beats_left = 0;
  bit   in_feed = 1'b0;
  int   exp_bub = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cur, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] ed [L];
    logic          ev [L];
    for (int i = 0; i < L; i++) begin
      ed[i] = '0;
      ev[i] = 1'b0;
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cur) begin
        ev[sb[k].lane] = 1'b1;
        ed[sb[k].lane] = sb[k].data;
        sb.delete(k);
      end
    end
    for (int i = 0; i < L; i++) begin
      chk($sformatf("lane%0d_valid", i), 64'(out_valid[i]), 64'(ev[i]));
      chk($sformatf("lane%0d_data", i), 64'(out_data[i*DW +: DW]), 64'(ed[i]));
    end
    chk("done", 64'(done), 64'(cur == done_cyc));
    chk("busy", 64'(busy), 64'((cur >= busy_from) && (cur <= busy_until)));
`ifdef FEEDER_PERF_CNT_EN
    chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_bub));
`endif
  endtask

  // Drive one cycle of inputs, advance one clock, then check outputs.
  task automatic step(input bit st, input logic [LW-1:0] len, input bit v,
                      input logic [L*DW-1:0] d);
    bit busy_now;
    bit acc;
    bit sacc;
    start    = st;
    tile_len = len;
    in_valid = v;
    in_data  = d;
    busy_now = (cur >= busy_from) && (cur <= busy_until);
    acc      = v && in_feed;
    sacc     = st && (len != 0) && !busy_now;
    chk("in_ready", 64'(in_ready), 64'(in_feed));
    if (acc) begin
      for (int i = 0; i < L; i++) begin
        sb.push_back('{cur + i + 1, i, d[i*DW +: DW]});
      end
    end
    @(posedge clk);
    if (in_feed && !acc && exp_bub < 65535) exp_bub++;
    if (acc) begin
      beats_left--;
      if (beats_left == 0) begin
        in_feed    = 1'b0;
        done_cyc   = cur + L;
        busy_until = done_cyc;
      end
    end
    if (sacc) begin
      in_feed    = 1'b1;
      beats_left = int'(len);
      busy_from  = cur + 1;
      busy_until = 1000000000;
      exp_bub    = 0;
    end
    cur++;
    #1;
    check_outputs();
  endtask

  function automatic logic [L*DW-1:0] rep(input logic [DW-1:0] x);
    return {L{x}};
  endfunction

  function automatic logic [L*DW-1:0] rnd();
    logic [L*DW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; tile_len = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Back-to-back tile, K=3.
    step(1'b1, 8'd3, 1'b0, '0);
    step(1'b0, '0, 1'b1, rep(32'h11));
    step(1'b0, '0, 1'b1, rep(32'h22));
    step(1'b0, '0, 1'b1, rep(32'h33));
    idle(5);

    // start with tile_len 0 is ignored.
    step(1'b1, 8'd0, 1'b0, '0);
    idle(2);

    // Bubble between two beats.
    step(1'b1, 8'd2, 1'b0, '0);
    step(1'b0, '0, 1'b1, rep(32'hA1));
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, rep(32'hA2));
    idle(6);

    // start during FEED must not relatch K; distinct data per lane.
    step(1'b1, 8'd2, 1'b0, '0);
    step(1'b0, '0, 1'b1, rnd());
    step(1'b1, 8'd9, 1'b0, '0);
    step(1'b1, 8'd9, 1'b1, rnd());
    idle(5);

    // in_valid held in IDLE and DRAIN; next tile starts on first IDLE cycle.
    step(1'b0, '0, 1'b1, rep(32'hDEAD));
    step(1'b1, 8'd1, 1'b1, rep(32'hBEEF));
    step(1'b0, '0, 1'b1, rep(32'hC0DE));
    for (int i = 0; i < L; i++) step(1'b0, '0, 1'b1, rnd());
    step(1'b1, 8'd2, 1'b1, rnd());
    step(1'b0, '0, 1'b1, rnd());
    step(1'b0, '0, 1'b1, rnd());
    for (int i = 0; i < L + 1; i++) step(1'b0, '0, 1'b1, rnd());

    // K=4 with three idle FEED cycles, then a new start clears the counter.
    step(1'b1, 8'd4, 1'b0, '0);
    step(1'b0, '0, 1'b1, rnd());
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, rnd());
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, rnd());
    step(1'b0, '0, 1'b1, rnd());
    idle(5);
    step(1'b1, 8'd1, 1'b0, '0);
    step(1'b0, '0, 1'b1, rnd());
    idle(5);

    // Random valid pattern over a longer tile.
    step(1'b1, 8'd10, 1'b0, '0);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'(($urandom % 3) != 0), rnd());
    idle(2);

    // Reset mid-tile: outputs clear immediately, tile abandoned.
    step(1'b1, 8'd5, 1'b0, '0);
    step(1'b0, '0, 1'b1, rep(32'h55));
    step(1'b0, '0, 1'b1, rep(32'h66));
    rst_n = 1'b0;
    #1;
    chk("rst_out_data", 64'(out_data != '0), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
`ifdef FEEDER_PERF_CNT_EN
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));
`endif
    sb.delete();
    in_feed = 1'b0; beats_left = 0; busy_until = -1; done_cyc = -1; exp_bub = 0;
    @(posedge clk);
    cur++;
    #1;
    check_outputs();
    rst_n = 1'b1;
    idle(6);

    // A tile after reset works normally.
    step(1'b1, 8'd2, 1'b0, '0);
    step(1'b0, '0, 1'b1, rnd());
    step(1'b0, '0, 1'b1, rnd());
    idle(5);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder for the systolic MAC array. It accepts one vector beat per cycle, with one element per array row, over a valid/ready handshake. It re-times the beat into a diagonal wavefront: lane i is delayed i cycles, so element k of every row reaches its edge PE in the correct systolic phase. Lane outputs drive the `A_in` ports of the array's left-column PEs. The array is free-running, so the feeder shifts every cycle and fills gaps with zero bubbles.

## Interface
- `DATA_WIDTH`, 32, element width (matches PE operand width)
- `LANES`, 4, number of array rows fed; ≥2
- `LEN_WIDTH`, 8, width of tile length field
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a tile; sampled only in IDLE
- `tile_len`  in  LEN_WIDTH  beats in tile (K); sampled with `start`
- `in_valid`  in  1  beat present
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_data`  in  LANES*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- `out_data`  out  LANES*DATA_WIDTH  skewed lane outputs, registered
- `out_valid`  out  LANES  per-lane valid, registered
- `busy`  out  1  high in FEED or DRAIN
- `done`  out  1  one-cycle pulse when last element leaves last lane
- `bubble_cnt`  out  16  present only with `FEEDER_PERF_CNT_EN`

## Operation
- FSM states: IDLE, FEED, DRAIN.
- IDLE → FEED when `start && tile_len != 0`. Latch K and clear the beat counter. `start` with `tile_len == 0` is ignored.
- FEED:
  - `in_ready = 1`, combinational from state.
  - An accepted beat is injected into lane-0 position of every delay line with valid=1, and the beat counter increments.
  - In a cycle with no accepted beat, inject data=0, valid=0 (a bubble).
  - When the K-th beat is accepted, go to DRAIN next cycle.
- DRAIN:
  - `in_ready = 0`. Zero bubbles are injected.
  - The counter runs LANES cycles, then returns to IDLE.
- Delay lines:
  - Lane i is an (i+1)-stage register chain, counting the output register, carrying data plus valid.
  - Chains shift every cycle in all states, with zeros injected in IDLE and DRAIN.
- `start` while `busy` is ignored. The next tile may start on the first IDLE cycle.
- `in_ready` in IDLE/DRAIN is 0; beats offered there are not consumed.

## Timing
- Reset (async assert) values:
  - `out_data` = 0, `out_valid` = 0, `busy` = 0, `done` = 0, `in_ready` = 0, `bubble_cnt` = 0.
  - State is IDLE and all delay stages are cleared.
- Reset mid-tile abandons the tile; no `done` is produced.
- `busy` rises the cycle after `start` is accepted.
- A beat accepted at cycle t appears on lane i at cycle t+i+1 with `out_valid[i] = 1`.
- With last beat accepted at t_L:
  - `done` = 1 at cycle t_L+LANES, the same cycle `out_valid[LANES-1]` shows beat K.
  - `busy` = 0 from t_L+LANES+1.
- Back-to-back beats give a full diagonal with no gaps. Minimum tile duration is K+LANES cycles after `start`.
- Bubble cycles appear as `out_valid[i] = 0`, `out_data` lane = 0, along the same diagonal.

## Configuration
- `FEEDER_PERF_CNT_EN` defined:
  - Adds output `bubble_cnt[15:0]`, which counts FEED cycles with no accepted beat.
  - The counter saturates at 0xFFFF and clears on an accepted `start`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use LANES=4 and DATA_WIDTH=32.
- **Reset:** assert `rst`=0 mid-stream, then release → all outputs 0 immediately on assert, state IDLE, no `done`.
- **Back-to-back tile:** `start`, `tile_len`=3, beats 0x11/0x22/0x33 on all lanes, accepted at t=1,2,3.
  - Lane 0 shows 0x11/0x22/0x33 at t=2..4.
  - Lane 3 shows them at t=5..7.
  - `done` at t=7; `busy` low at t=8.
- **Bubble:** `tile_len`=2, `in_valid` low one cycle between beats.
  - Lane i shows beat, zero with `out_valid[i]`=0, beat.
  - `done` is one cycle later than the no-bubble case.
- **Ignored starts:** `start` with `tile_len`=0 in IDLE → `busy` stays 0. `start` during FEED → no effect on K or counter.
- **Ready gating:** hold `in_valid`=1 in IDLE and DRAIN → `in_ready`=0 and no valid appears on any lane.
- **Perf counter:** with `FEEDER_PERF_CNT_EN`, a tile of K=4 with 3 idle FEED cycles → `bubble_cnt`=3. The next `start` clears it to 0.
